adc_spi_reader: RTL and testbench
=================================

// Module: adc_spi_reader
// PURPOSE
//  Serial-read master for a dual-channel 12-bit SPI ADC (AD7476-style, Pmod AD1 pinout).
//  Generates cs_n and the divided serial clock sclk internally from clk.
//  Shifts in one 16-bit frame per channel and presents two parallel 12-bit samples with a valid strobe.
//  Sits between the ADC pins and the sample-processing logic; single clock domain (clk).
// PARAMETERS
//  CLK_DIV      244  sclk half-period minus one, in clk cycles; half-period = CLK_DIV+1; legal >= 2
//  FRAME_BITS   16   sclk rising edges per conversion frame
//  DATA_BITS    12   LSBs of frame kept as sample; leading FRAME_BITS-DATA_BITS bits discarded
//  QUIET_CYCLES 16   clk cycles cs_n held high after a frame before a new start is accepted; >= 1
// PORTS
//  clk     in   1          system clock
//  rst_n   in   1          asynchronous active-low reset
//  start   in   1          request one conversion; sampled only in IDLE
//  sdata0  in   1          ADC channel 0 serial data (asynchronous to clk)
//  sdata1  in   1          ADC channel 1 serial data (asynchronous to clk)
//  cs_n    out  1          ADC chip select, active low
//  sclk    out  1          ADC serial clock; idles high
//  data0   out  DATA_BITS  last completed channel-0 sample
//  data1   out  DATA_BITS  last completed channel-1 sample
//  valid   out  1          one-cycle pulse: data0/data1 updated this cycle
//  busy    out  1          high in CONV and QUIET
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, cs_n=1, sclk=1, data0=data1=0, valid=0, busy=0, counters/shift regs cleared.
//  sdata0/1 each pass through a 2-flop synchronizer; all sampling uses the synchronized copies.
//  States: IDLE -> CONV -> QUIET -> IDLE.
//  IDLE: cs_n=1, sclk=1. start=1 at edge -> CONV; at that edge cs_n<=0, div count<=0, edge count<=0.
//  CONV: div counter runs 0..CLK_DIV; on count==CLK_DIV toggle sclk and reload 0.
//   - First toggle (1->0) CLK_DIV+1 cycles after cs_n falls.
//   - On each 0->1 toggle, shift synchronized bit into each channel's shift reg, MSB first.
//   - Rising edge N occurs (2N)*(CLK_DIV+1) cycles after cs_n falls.
//  At the FRAME_BITS-th rising edge (same clk edge as that sclk 0->1):
//   - data0/data1 <= low DATA_BITS of {shift, new bit}; valid<=1 for exactly that one cycle.
//   - cs_n<=1; sclk stays 1; -> QUIET.
//  QUIET: cs_n=1, sclk=1 for QUIET_CYCLES cycles, then -> IDLE.
//  start while busy=1: ignored (not queued). start held high: new frame each pass through IDLE.
//  Leading discarded bits are not checked; nonzero values are dropped silently.
//  data0/data1 hold value between valid pulses; never change outside a valid cycle except reset.
//  Reset mid-frame: immediate abort, outputs to reset values; no valid; next frame needs a new start.
//  Frame latency, cs_n fall to valid: 2*FRAME_BITS*(CLK_DIV+1) cycles (7840 at defaults).
//  Sync delay (2 clk) must stay below half-period; guaranteed by CLK_DIV >= 2.
// TESTING (CLK_DIV=3, QUIET_CYCLES=8 unless stated)
//  1 Reset: rst_n=0 mid-sim -> cs_n=1, sclk=1, data0=data1=0, valid=0, busy=0 without waiting for a clk edge.
//  2 Single frame: start pulse, ADC model drives 0x0ABC ch0 / 0x0123 ch1 on sclk falls ->
//    valid exactly 128 cycles after cs_n falls; data0=0xABC, data1=0x123; 16 sclk rises; sclk period 8 clk.
//  3 Leading bits: model sends 0xFFFF / 0x8001 -> data0=0xFFF, data1=0x001.
//  4 Start while busy: pulse start mid-CONV and mid-QUIET -> one frame only; exactly 8 QUIET cycles;
//    start held high -> back-to-back frames spaced 128+8+1 cycles, one valid each.
//  5 Reset mid-frame: assert rst_n=0 after 5 rising edges -> cs_n=1, sclk=1 at once, no valid;
//    after release and new start -> clean full frame with correct data.
//  6 Default CLK_DIV=244: one frame -> sclk half-period 245 cycles, valid 7840 cycles after cs_n falls.

Source files
------------

// File: rtl/adc_spi_reader.sv
// rtl/adc_spi_reader.sv - dual-channel 12-bit SPI ADC serial-read master
module adc_spi_reader #(
    parameter int CLK_DIV      = 244,
    parameter int FRAME_BITS   = 16,
    parameter int DATA_BITS    = 12,
    parameter int QUIET_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 sdata0,
    input  logic                 sdata1,
    output logic                 cs_n,
    output logic                 sclk,
    output logic [DATA_BITS-1:0] data0,
    output logic [DATA_BITS-1:0] data1,
    output logic                 valid,
    output logic                 busy
);
    localparam int DIV_W  = $clog2(CLK_DIV + 1);
    localparam int EDGE_W = $clog2(FRAME_BITS + 1);
    localparam int Q_W    = $clog2(QUIET_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, CONV, QUIET} state_t;

    state_t                 state_q, state_d;
    logic                   cs_n_q, cs_n_d;
    logic                   sclk_q, sclk_d;
    logic [DIV_W-1:0]       div_q, div_d;
    logic [EDGE_W-1:0]      edge_q, edge_d;
    logic [Q_W-1:0]         quiet_q, quiet_d;
    logic [DATA_BITS-2:0]   sh0_q, sh0_d, sh1_q, sh1_d;
    logic [DATA_BITS-1:0]   data0_q, data0_d, data1_q, data1_d;
    logic                   valid_q, valid_d;
    logic                   s0_meta, s0_sync, s1_meta, s1_sync;
    logic [DATA_BITS-1:0]   frame0, frame1;

    // Only the newest DATA_BITS bits are kept, so leading frame bits fall off the top
    assign frame0 = {sh0_q, s0_sync};
    assign frame1 = {sh1_q, s1_sync};

    always_comb begin
        state_d = state_q;
        cs_n_d  = cs_n_q;
        sclk_d  = sclk_q;
        div_d   = div_q;
        edge_d  = edge_q;
        quiet_d = quiet_q;
        sh0_d   = sh0_q;
        sh1_d   = sh1_q;
        data0_d = data0_q;
        data1_d = data1_q;
        valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                cs_n_d = 1'b1;
                sclk_d = 1'b1;
                if (start) begin
                    state_d = CONV;
                    cs_n_d  = 1'b0;
                    div_d   = '0;
                    edge_d  = '0;
                end
            end
            CONV: begin
                if (div_q == DIV_W'(CLK_DIV)) begin
                    div_d  = '0;
                    sclk_d = ~sclk_q;
                    if (!sclk_q) begin
                        sh0_d  = frame0[DATA_BITS-2:0];
                        sh1_d  = frame1[DATA_BITS-2:0];
                        edge_d = edge_q + EDGE_W'(1);
                        if (edge_q == EDGE_W'(FRAME_BITS - 1)) begin
                            data0_d = frame0;
                            data1_d = frame1;
                            valid_d = 1'b1;
                            cs_n_d  = 1'b1;
                            quiet_d = '0;
                            state_d = QUIET;
                        end
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            QUIET: begin
                cs_n_d = 1'b1;
                sclk_d = 1'b1;
                if (quiet_q == Q_W'(QUIET_CYCLES - 1)) begin
                    state_d = IDLE;
                end else begin
                    quiet_d = quiet_q + Q_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cs_n_d  = 1'b1;
                sclk_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cs_n_q  <= 1'b1;
            sclk_q  <= 1'b1;
            div_q   <= '0;
            edge_q  <= '0;
            quiet_q <= '0;
            sh0_q   <= '0;
            sh1_q   <= '0;
            data0_q <= '0;
            data1_q <= '0;
            valid_q <= 1'b0;
            s0_meta <= 1'b0;
            s0_sync <= 1'b0;
            s1_meta <= 1'b0;
            s1_sync <= 1'b0;
        end else begin
            state_q <= state_d;
            cs_n_q  <= cs_n_d;
            sclk_q  <= sclk_d;
            div_q   <= div_d;
            edge_q  <= edge_d;
            quiet_q <= quiet_d;
            sh0_q   <= sh0_d;
            sh1_q   <= sh1_d;
            data0_q <= data0_d;
            data1_q <= data1_d;
            valid_q <= valid_d;
            s0_meta <= sdata0;
            s0_sync <= s0_meta;
            s1_meta <= sdata1;
            s1_sync <= s1_meta;
        end
    end

    assign cs_n  = cs_n_q;
    assign sclk  = sclk_q;
    assign data0 = data0_q;
    assign data1 = data1_q;
    assign valid = valid_q;
    assign busy  = (state_q != IDLE);
endmodule

// File: tb/tb_adc_spi_reader.sv
// tb/tb_adc_spi_reader.sv - directed self-checking bench for adc_spi_reader
module tb_adc_spi_reader;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, start_a, start_b;
    logic sd0_a = 1'b0, sd1_a = 1'b0, sd0_b = 1'b0, sd1_b = 1'b0;
    logic cs_n_a, sclk_a, valid_a, busy_a, cs_n_b, sclk_b, valid_b, busy_b;
    logic [11:0] data0_a, data1_a, data0_b, data1_b;
    logic [15:0] w0_a, w1_a, w0_b, w1_b;

    adc_spi_reader #(.CLK_DIV(3), .QUIET_CYCLES(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .sdata0(sd0_a), .sdata1(sd1_a),
        .cs_n(cs_n_a), .sclk(sclk_a), .data0(data0_a), .data1(data1_a),
        .valid(valid_a), .busy(busy_a)
    );

    adc_spi_reader dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .sdata0(sd0_b), .sdata1(sd1_b),
        .cs_n(cs_n_b), .sclk(sclk_b), .data0(data0_b), .data1(data1_b),
        .valid(valid_b), .busy(busy_b)
    );

    // ADC models: next bit, MSB first, on each sclk fall; index rewinds when cs_n rises
    int bi_a = 15, bi_b = 15;
    always @(negedge sclk_a or posedge cs_n_a) begin
        if (cs_n_a) bi_a = 15;
        else if (bi_a >= 0) begin
            sd0_a = w0_a[bi_a];
            sd1_a = w1_a[bi_a];
            bi_a  = bi_a - 1;
        end
    end
    always @(negedge sclk_b or posedge cs_n_b) begin
        if (cs_n_b) bi_b = 15;
        else if (bi_b >= 0) begin
            sd0_b = w0_b[bi_b];
            sd1_b = w1_b[bi_b];
            bi_b  = bi_b - 1;
        end
    end

    int cyc = 0;
    int n_rise_a = 0, n_valid_a = 0, n_fall_a = 0, fall_a = 0, pfall_a = 0;
    int vcyc_a = 0, pvcyc_a = 0, tog_a = 0, half_a = 0, bfall_a = 0;
    int n_valid_b = 0, fall_b = 0, vcyc_b = 0, tog_b = 0, half_b = 0;
    logic p_sclk_a = 1'b1, p_cs_a = 1'b1, p_busy_a = 1'b0, p_sclk_b = 1'b1, p_cs_b = 1'b1;

    always @(posedge clk) begin
        #1;
        cyc = cyc + 1;
        if (sclk_a && !p_sclk_a) n_rise_a = n_rise_a + 1;
        if (sclk_a != p_sclk_a && !p_cs_a) begin half_a = cyc - tog_a; tog_a = cyc; end
        if (!cs_n_a && p_cs_a) begin pfall_a = fall_a; fall_a = cyc; n_fall_a = n_fall_a + 1; end
        if (valid_a) begin n_valid_a = n_valid_a + 1; pvcyc_a = vcyc_a; vcyc_a = cyc; end
        if (!busy_a && p_busy_a) bfall_a = cyc;
        if (sclk_b != p_sclk_b && !p_cs_b) begin half_b = cyc - tog_b; tog_b = cyc; end
        if (!cs_n_b && p_cs_b) fall_b = cyc;
        if (valid_b) begin n_valid_b = n_valid_b + 1; vcyc_b = cyc; end
        p_sclk_a = sclk_a; p_cs_a = cs_n_a; p_busy_a = busy_a;
        p_sclk_b = sclk_b; p_cs_b = cs_n_b;
    end

    int n_checks = 0, n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_a();
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
    endtask

    task automatic wait_valid_a(input int budget, input string tag);
        int v0;
        v0 = n_valid_a;
        for (int i = 0; i < budget && n_valid_a == v0; i++) @(negedge clk);
        check(tag, n_valid_a - v0, 1);
    endtask

    int r0, v0, f0;

    initial begin
        rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
        w0_a = 16'h0; w1_a = 16'h0; w0_b = 16'h0; w1_b = 16'h0;
        repeat (3) @(negedge clk);
        check("rst_cs_n", cs_n_a, 1);
        check("rst_sclk", sclk_a, 1);
        check("rst_data0", data0_a, 0);
        check("rst_data1", data1_a, 0);
        check("rst_valid", valid_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_b_sclk", sclk_b, 1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // single frame
        w0_a = 16'h0ABC; w1_a = 16'h0123;
        r0 = n_rise_a;
        pulse_a();
        wait_valid_a(300, "t2_valid_seen");
        check("t2_latency", vcyc_a - fall_a, 128);
        check("t2_data0", data0_a, 12'hABC);
        check("t2_data1", data1_a, 12'h123);
        check("t2_rises", n_rise_a - r0, 16);
        check("t2_half_period", half_a, 4);
        repeat (20) @(negedge clk);
        check("t2_idle_busy", busy_a, 0);
        check("t2_hold_data0", data0_a, 12'hABC);

        // leading bits discarded
        w0_a = 16'hFFFF; w1_a = 16'h8001;
        pulse_a();
        wait_valid_a(300, "t3_valid_seen");
        check("t3_data0", data0_a, 12'hFFF);
        check("t3_data1", data1_a, 12'h001);
        repeat (20) @(negedge clk);

        // start while busy is ignored
        w0_a = 16'h0555; w1_a = 16'h0AAA;
        v0 = n_valid_a; f0 = n_fall_a;
        pulse_a();
        repeat (30) @(negedge clk);
        pulse_a();
        wait_valid_a(300, "t4_valid_seen");
        repeat (3) @(negedge clk);
        check("t4_busy_in_quiet", busy_a, 1);
        pulse_a();
        for (int i = 0; i < 50 && busy_a; i++) @(negedge clk);
        check("t4_quiet_len", bfall_a - vcyc_a, 8);
        repeat (150) @(negedge clk);
        check("t4_one_valid", n_valid_a - v0, 1);
        check("t4_one_frame", n_fall_a - f0, 1);
        check("t4_data0", data0_a, 12'h555);
        check("t4_data1", data1_a, 12'hAAA);

        // start held high: back-to-back frames
        v0 = n_valid_a;
        start_a = 1'b1;
        wait_valid_a(300, "t4_held_v1");
        wait_valid_a(300, "t4_held_v2");
        start_a = 1'b0;
        check("t4_valid_spacing", vcyc_a - pvcyc_a, 137);
        check("t4_frame_spacing", fall_a - pfall_a, 137);
        repeat (150) @(negedge clk);
        check("t4_held_valids", n_valid_a - v0, 2);

        // reset mid-frame
        w0_a = 16'h0321; w1_a = 16'h0654;
        r0 = n_rise_a;
        pulse_a();
        for (int i = 0; i < 100 && (n_rise_a - r0) < 5; i++) @(negedge clk);
        check("t5_five_rises", n_rise_a - r0, 5);
        for (int i = 0; i < 10 && sclk_a; i++) @(negedge clk);
        check("t5_sclk_low", sclk_a, 0);
        v0 = n_valid_a;
        rst_n = 1'b0;
        #1;
        check("t5_cs_n_async", cs_n_a, 1);
        check("t5_sclk_async", sclk_a, 1);
        check("t5_busy_async", busy_a, 0);
        check("t5_data0_async", data0_a, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("t5_no_valid", n_valid_a - v0, 0);
        check("t5_stays_idle", cs_n_a, 1);
        pulse_a();
        wait_valid_a(300, "t5_valid_seen");
        check("t5_latency", vcyc_a - fall_a, 128);
        check("t5_data0", data0_a, 12'h321);
        check("t5_data1", data1_a, 12'h654);

        // default divider
        w0_b = 16'h0DEF; w1_b = 16'hF246;
        v0 = n_valid_b;
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        for (int i = 0; i < 9000 && n_valid_b == v0; i++) @(negedge clk);
        check("t6_valid_seen", n_valid_b - v0, 1);
        check("t6_latency", vcyc_b - fall_b, 7840);
        check("t6_half_period", half_b, 245);
        check("t6_data0", data0_b, 12'hDEF);
        check("t6_data1", data1_b, 12'h246);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
